// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI burst target: FSM state encoding and the
// mode-dependent choice of which SCK edge samples SDI.
package spi_target_pkg;

  typedef enum logic [2:0] {
    StStall,  // waiting for cs to be seen high before accepting a frame
    StIdle,   // cs high, counters cleared, waiting for cs to fall
    StCmd,    // receiving the command word, shifting out status
    StStage,  // one cycle: load the next tx word
    StData,   // receiving / transmitting a data word
    StFull    // MAX_WORDS received; further sample edges are an overrun
  } spi_state_e;

  // SDI is sampled on the rising SCK edge when CPOL == CPHA, otherwise on the
  // falling edge. The opposite edge is the shift edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for the asynchronous SPI pins. All outputs are registered one
// cycle after the last synchroniser stage so that levels and edge strobes line
// up in the same clk cycle.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_sdi,
  input  logic i_cs,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_sdi,
  output logic o_cs,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  logic [SYNC_STAGES-1:0] r_sck_pipe;
  logic [SYNC_STAGES-1:0] r_sdi_pipe;
  logic [SYNC_STAGES-1:0] r_cs_pipe;
  logic                   r_sck_last;
  logic                   r_sck_rise;
  logic                   r_sck_fall;
  logic                   r_sdi;
  logic                   r_cs;
  logic                   r_cs_rise;
  logic                   r_cs_fall;

  logic w_sck_s;
  logic w_sdi_s;
  logic w_cs_s;

  assign w_sck_s = r_sck_pipe[SYNC_STAGES-1];
  assign w_sdi_s = r_sdi_pipe[SYNC_STAGES-1];
  assign w_cs_s  = r_cs_pipe[SYNC_STAGES-1];

  // Synchroniser chains plus registered edge strobes. The cs chain resets low
  // so that a frame already in progress at reset release is never mistaken
  // for a fresh one: the FSM waits for a real high level first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_pipe <= '0;
      r_sdi_pipe <= '0;
      r_cs_pipe  <= '0;
      r_sck_last <= 1'b0;
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_sdi      <= 1'b0;
      r_cs       <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
    end else begin
      r_sck_pipe <= {r_sck_pipe[SYNC_STAGES-2:0], i_sck};
      r_sdi_pipe <= {r_sdi_pipe[SYNC_STAGES-2:0], i_sdi};
      r_cs_pipe  <= {r_cs_pipe[SYNC_STAGES-2:0], i_cs};
      r_sck_last <= w_sck_s;
      r_sck_rise <= w_sck_s & ~r_sck_last;
      r_sck_fall <= ~w_sck_s & r_sck_last;
      r_sdi      <= w_sdi_s;
      r_cs       <= w_cs_s;
      r_cs_rise  <= w_cs_s & ~r_cs;
      r_cs_fall  <= ~w_cs_s & r_cs;
    end
  end

  assign o_sck_rise = r_sck_rise;
  assign o_sck_fall = r_sck_fall;
  assign o_sdi      = r_sdi;
  assign o_cs       = r_cs;
  assign o_cs_rise  = r_cs_rise;
  assign o_cs_fall  = r_cs_fall;

endmodule

// File: rtl/spi_burst_target.sv
// SPI target carrying one command word followed by 1..MAX_WORDS full-duplex
// data words per cs-low frame. All SPI modes; pins are synchronised into clk.
module spi_burst_target
  import spi_target_pkg::*;
#(
  parameter int unsigned CMD_BITS    = 8,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned MAX_WORDS   = 4,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_sck,
  input  logic                             i_sdi,
  input  logic                             i_cs,
  output logic                             o_sdo,
  input  logic [CMD_BITS-1:0]              i_status,
  output logic [CMD_BITS-1:0]              o_cmd,
  output logic                             o_cmd_valid,
  output logic                             o_tx_req,
  input  logic [WORD_BITS-1:0]             i_tx_word,
  output logic [WORD_BITS-1:0]             o_rx_word,
  output logic                             o_rx_valid,
  output logic [$clog2(MAX_WORDS+1)-1:0]   o_word_index,
  output logic                             o_xfer_done,
  output logic                             o_xfer_abort,
  output logic                             o_overrun
);

  // The tx shift register is shared by the status and data phases, so it is
  // as wide as the wider word; shorter words are left-justified.
  localparam int unsigned SR_W   = (CMD_BITS > WORD_BITS) ? CMD_BITS : WORD_BITS;
  localparam int unsigned BCNT_W = $clog2(SR_W + 1);
  localparam int unsigned WIDX_W = $clog2(MAX_WORDS + 1);
  localparam bit          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  localparam logic [BCNT_W-1:0] CMD_LAST  = BCNT_W'(CMD_BITS);
  localparam logic [BCNT_W-1:0] WORD_LAST = BCNT_W'(WORD_BITS);
  localparam logic [WIDX_W-1:0] WIDX_MAX  = WIDX_W'(MAX_WORDS);

  // Synchronised pin view
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sdi;
  logic w_cs;
  logic w_cs_rise;
  logic w_cs_fall;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sck      (i_sck),
    .i_sdi      (i_sdi),
    .i_cs       (i_cs),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_sdi      (w_sdi),
    .o_cs       (w_cs),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall)
  );

  logic w_sample;
  logic w_shift;

  assign w_sample = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_shift  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

  // State and datapath registers
  spi_state_e           r_state;
  logic [BCNT_W-1:0]    r_bit_cnt;
  logic [WIDX_W-1:0]    r_word_idx;
  logic [CMD_BITS-1:0]  r_cmd_sr;
  logic [WORD_BITS-1:0] r_rx_sr;
  logic [SR_W-1:0]      r_tx_sr;
  logic [CMD_BITS-1:0]  r_cmd;
  logic [WORD_BITS-1:0] r_rx_word;
  logic                 r_overrun;
  logic                 r_cmd_valid;
  logic                 r_tx_req;
  logic                 r_rx_valid;
  logic                 r_done;
  logic                 r_abort;
  logic                 r_sdo;

  // Next-state values
  spi_state_e           w_state_nxt;
  logic [BCNT_W-1:0]    w_bit_cnt_nxt;
  logic [WIDX_W-1:0]    w_word_idx_nxt;
  logic [CMD_BITS-1:0]  w_cmd_sr_nxt;
  logic [WORD_BITS-1:0] w_rx_sr_nxt;
  logic [SR_W-1:0]      w_tx_sr_nxt;
  logic [CMD_BITS-1:0]  w_cmd_nxt;
  logic [WORD_BITS-1:0] w_rx_word_nxt;
  logic                 w_overrun_nxt;
  logic                 w_cmd_valid_nxt;
  logic                 w_tx_req_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_done_nxt;
  logic                 w_abort_nxt;
  logic                 w_sdo_en_nxt;

  // Helper terms
  logic [BCNT_W-1:0]    w_bit_cnt_inc;
  logic [WIDX_W-1:0]    w_word_idx_inc;
  logic [CMD_BITS-1:0]  w_cmd_shifted;
  logic [WORD_BITS-1:0] w_rx_shifted;
  logic [SR_W-1:0]      w_tx_shifted;
  logic [SR_W-1:0]      w_status_ext;
  logic [SR_W-1:0]      w_tx_word_ext;

  assign w_bit_cnt_inc  = r_bit_cnt + 1'b1;
  assign w_word_idx_inc = r_word_idx + 1'b1;
  assign w_cmd_shifted  = CMD_BITS'({r_cmd_sr, w_sdi});
  assign w_rx_shifted   = WORD_BITS'({r_rx_sr, w_sdi});
  assign w_tx_shifted   = {r_tx_sr[SR_W-2:0], 1'b0};
  assign w_status_ext   = SR_W'(i_status) << (SR_W - CMD_BITS);
  assign w_tx_word_ext  = SR_W'(i_tx_word) << (SR_W - WORD_BITS);

  // Next-state and datapath update. A cs rise is checked before any SCK edge
  // so it wins when both land in the same cycle. tx_sr only shifts once the
  // current word has seen a sample edge, which keeps the MSB on sdo ahead of
  // the first sample edge in every mode.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_word_idx_nxt  = r_word_idx;
    w_cmd_sr_nxt    = r_cmd_sr;
    w_rx_sr_nxt     = r_rx_sr;
    w_tx_sr_nxt     = r_tx_sr;
    w_cmd_nxt       = r_cmd;
    w_rx_word_nxt   = r_rx_word;
    w_overrun_nxt   = r_overrun;
    w_cmd_valid_nxt = 1'b0;
    w_tx_req_nxt    = 1'b0;
    w_rx_valid_nxt  = 1'b0;
    w_done_nxt      = 1'b0;
    w_abort_nxt     = 1'b0;

    case (r_state)
      StStall: begin
        if (w_cs) begin
          w_state_nxt = StIdle;
        end
      end

      StIdle: begin
        w_bit_cnt_nxt  = '0;
        w_word_idx_nxt = '0;
        if (w_cs_fall) begin
          w_tx_sr_nxt   = w_status_ext;
          w_cmd_sr_nxt  = '0;
          w_rx_sr_nxt   = '0;
          w_overrun_nxt = 1'b0;
          w_state_nxt   = StCmd;
        end
      end

      StCmd: begin
        if (w_cs_rise) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = StIdle;
        end else if (w_sample) begin
          w_cmd_sr_nxt  = w_cmd_shifted;
          w_bit_cnt_nxt = w_bit_cnt_inc;
          if (w_bit_cnt_inc == CMD_LAST) begin
            w_cmd_nxt       = w_cmd_shifted;
            w_cmd_valid_nxt = 1'b1;
            w_tx_req_nxt    = 1'b1;
            w_bit_cnt_nxt   = '0;
            w_state_nxt     = StStage;
          end
        end else if (w_shift && (r_bit_cnt != '0)) begin
          w_tx_sr_nxt = w_tx_shifted;
        end
      end

      StStage: begin
        // Sits on a word boundary: ending here is clean only if a data word
        // has already completed.
        if (w_cs_rise) begin
          w_done_nxt  = (r_word_idx != '0);
          w_abort_nxt = (r_word_idx == '0);
          w_state_nxt = StIdle;
        end else begin
          w_tx_sr_nxt = w_tx_word_ext;
          w_state_nxt = StData;
        end
      end

      StData: begin
        if (w_cs_rise) begin
          if ((r_bit_cnt != '0) || (r_word_idx == '0)) begin
            w_abort_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
          w_state_nxt = StIdle;
        end else if (w_sample) begin
          w_rx_sr_nxt   = w_rx_shifted;
          w_bit_cnt_nxt = w_bit_cnt_inc;
          if (w_bit_cnt_inc == WORD_LAST) begin
            w_rx_word_nxt  = w_rx_shifted;
            w_rx_valid_nxt = 1'b1;
            w_word_idx_nxt = w_word_idx_inc;
            w_bit_cnt_nxt  = '0;
            if (w_word_idx_inc < WIDX_MAX) begin
              w_tx_req_nxt = 1'b1;
              w_state_nxt  = StStage;
            end else begin
              w_state_nxt = StFull;
            end
          end
        end else if (w_shift && (r_bit_cnt != '0)) begin
          w_tx_sr_nxt = w_tx_shifted;
        end
      end

      StFull: begin
        if (w_cs_rise) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else if (w_sample) begin
          w_overrun_nxt = 1'b1;
          w_state_nxt   = StStall;
        end
      end

      default: begin
        w_state_nxt = StStall;
      end
    endcase

    w_sdo_en_nxt = (w_state_nxt == StCmd) || (w_state_nxt == StStage) ||
                   (w_state_nxt == StData);
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StStall;
      r_bit_cnt   <= '0;
      r_word_idx  <= '0;
      r_cmd_sr    <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_cmd       <= '0;
      r_rx_word   <= '0;
      r_overrun   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_tx_req    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_sdo       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_cmd_sr    <= w_cmd_sr_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_cmd       <= w_cmd_nxt;
      r_rx_word   <= w_rx_word_nxt;
      r_overrun   <= w_overrun_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_done      <= w_done_nxt;
      r_abort     <= w_abort_nxt;
      r_sdo       <= w_tx_sr_nxt[SR_W-1] & w_sdo_en_nxt;
    end
  end

  assign o_sdo        = r_sdo;
  assign o_cmd        = r_cmd;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_tx_req     = r_tx_req;
  assign o_rx_word    = r_rx_word;
  assign o_rx_valid   = r_rx_valid;
  assign o_word_index = r_word_idx;
  assign o_xfer_done  = r_done;
  assign o_xfer_abort = r_abort;
  assign o_overrun    = r_overrun;

endmodule
